// File: rtl/m92_pkg.sv
// Shared VRAM geometry and requester naming for the B-D board fetch path.
package m92_pkg;

    localparam int VRAM_AW = 15;
    localparam int VRAM_DW = 16;

    typedef logic [VRAM_AW-1:0] vram_waddr_t;

    typedef enum logic [1:0] {
        LAYER_A   = 2'd0,
        LAYER_B   = 2'd1,
        LAYER_C   = 2'd2,
        ROWSCROLL = 2'd3
    } req_idx_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first eligible index after `last` wins.
// The sprite DMA arbiter uses it as well.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every output gets a default before the search loop, so no path
        // leaves one unassigned and no latch is inferred.
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!any && elig[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_fetch_arbiter.sv
// Arbitrates VRAM port B reads between the tile fetchers and the row-scroll
// fetcher. Each returned word is tagged back to its owner after a fixed latency.
module vram_fetch_arbiter
    import m92_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int AW      = VRAM_AW,
    parameter int DW      = VRAM_DW,
    parameter int RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*AW-1:0] addr,
    input  logic [NUM_REQ-1:0]    hi_prio,
    input  logic                  hold,
    output logic [NUM_REQ-1:0]    ack,
    output logic [NUM_REQ-1:0]    rvalid,
    output logic [DW-1:0]         rdata,
    output logic                  idle,
    output logic [AW-1:0]         vram_addr,
    input  logic [DW-1:0]         vram_q
);

    localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = RD_LAT + 1;
    localparam logic [IW-1:0] LAST_RST = IW'(NUM_REQ - 1);

    typedef struct packed {
        logic          valid;
        logic [IW-1:0] idx;
    } owner_t;

    logic [NUM_REQ-1:0]      hi_req;
    logic [NUM_REQ-1:0]      elig;
    logic [IW-1:0]           win_idx;
    logic                    win_any;
    logic [IW-1:0]           last_q, last_d;
    logic [AW-1:0]           vram_addr_q, vram_addr_d;
    owner_t [DEPTH-1:0]      pipe_q, pipe_d;
    logic                    pipe_busy;

    // The high-priority class shadows everyone else whenever any of it is asking.
    always_comb begin
        hi_req = req & hi_prio;
        if (reset || hold) begin
            elig = '0;
        end else if (|hi_req) begin
            elig = hi_req;
        end else begin
            elig = req;
        end
    end

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_pick (
        .elig  (elig),
        .last  (last_q),
        .grant (ack),
        .idx   (win_idx),
        .any   (win_any)
    );

    always_comb begin
        last_d      = last_q;
        vram_addr_d = vram_addr_q;
        if (win_any) begin
            last_d      = win_idx;
            vram_addr_d = addr[int'(win_idx)*AW +: AW];
        end
        pipe_d[0] = '{valid: win_any, idx: win_idx};
        for (int i = 1; i < DEPTH; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments only, so every
        // flop samples the pre-edge value of its neighbours.
        if (reset) begin
            last_q      <= LAST_RST;
            vram_addr_q <= '0;
            pipe_q      <= '0;
        end else begin
            last_q      <= last_d;
            vram_addr_q <= vram_addr_d;
            pipe_q      <= pipe_d;
        end
    end

    always_comb begin
        rvalid    = '0;
        pipe_busy = 1'b0;
        if (pipe_q[DEPTH-1].valid) begin
            rvalid[pipe_q[DEPTH-1].idx] = 1'b1;
        end
        for (int i = 0; i < DEPTH; i++) begin
            pipe_busy = pipe_busy | pipe_q[i].valid;
        end
    end

    assign vram_addr = vram_addr_q;
    assign rdata     = vram_q;
    assign idle      = ~|req & ~pipe_busy;

endmodule
